ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage directly upstream of the MIPS ALU.
- Captures decoded fields each clock and drives the ALU's data1, data2, ALU control and shift amount, with operands forwarded from the EX/MEM and MEM/WB results.
- Detects load-use hazards, inserts bubbles and stalls decode.
- Handles pipeline flush and downstream hold.

Parameters:
- DW, 32, operand/result width
- RW, 5, register-address width
- CW, 4, ALU control width
- CNTW, 16, bubble counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  RW  source register 1 address
- id_rt  in  RW  source register 2 address
- id_rd  in  RW  destination address (already muxed rt/rd)
- id_rs_data  in  DW  register-file value of rs
- id_rt_data  in  DW  register-file value of rt
- id_imm  in  DW  sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_alu_ctrl  in  CW  ALU operation code
- id_alu_src  in  1  1 = data2 uses immediate
- id_uses_rt  in  1  instruction reads rt
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- id_reg_write  in  1  writes register
- exmem_reg_write  in  1  EX/MEM stage writes register
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes register
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB write-back value
- flush  in  1  kill instruction entering this stage
- hold_in  in  1  downstream stall, freeze stage
- stall_id  out  1  load-use stall request to IF/ID
- ex_valid  out  1  stage holds a real instruction
- data1  out  DW  ALU operand 1
- data2  out  DW  ALU operand 2
- alu_ctrl  out  CW  ALU operation
- shamt  out  5  ALU shift amount
- store_data  out  DW  forwarded rt value for stores
- ex_rd  out  RW  destination
- ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  registered controls
- bubble_count  out  CNTW  load-use bubbles inserted

Behaviour:
- Reset: reset, synchronous, active-high.
  - All registered fields clear to 0, so ex_valid=0 and all controls=0.
  - bubble_count=0.
  - stall_id=0 after the edge.
- Per-edge priority: reset > flush > hold_in > load-use > normal load.
  - flush: stage loads a bubble (valid and all controls 0, data fields 0). This applies even if hold_in is high.
  - hold_in: all fields keep their values, except that the operand registers are overwritten with the current forwarded rs/rt values. This keeps a forward from being lost when its source retires during the hold. A rs/rt address of 0 stays at value 0.
  - load-use hazard: stage loads a bubble. bubble_count increments and saturates at all-ones.
  - Normal load: capture all id_* fields. Controls are gated by id_valid (id_valid=0 loads a bubble).
- Load-use hazard, combinational: ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)) & id_valid.
  - stall_id = hazard & ~flush & ~hold_in.
  - Decode holds its own register while stall_id=1.
  - After one bubble the load has moved to EX/MEM, so the hazard clears. Exactly one bubble is inserted per load-use pair.
- Forwarding, combinational on the registered rs/rt, evaluated separately for each operand:
  - Registered address 0 gives 0.
  - Otherwise, if exmem_reg_write & exmem_rd==addr, use exmem_result.
  - Otherwise, if memwb_reg_write & memwb_rd==addr, use memwb_result.
  - Otherwise, use the registered register-file value.
  - EX/MEM has priority over MEM/WB.
- Output mapping:
  - data1 = fwd_rs.
  - store_data = fwd_rt.
  - data2 = alu_src ? imm : fwd_rt. The immediate is never forwarded.
- alu_ctrl, shamt, ex_rd: registered copies. Forwarding never alters them.
- Write-back to decode bypass is provided by the register file and is not handled here.
- Zero-latency path: outputs are valid in the cycle after capture. The ALU samples them on its next edge.

Test Plan:
- Reset mid-stream: reset high for one edge while ex_valid=1 with add -> ex_valid=0, all controls 0, bubble_count=0 next cycle.
- EX/MEM forward priority: ex rs=3; exmem_rd=3 result 0x11; memwb_rd=3 result 0x22, both writing -> data1=0x11. Drop exmem_reg_write -> data1=0x22.
- Register 0: rs=0, exmem_rd=0, exmem_reg_write=1, result 0xFF -> data1=0.
- Load-use: lw to rd=5 in EX; decode add rs=5 -> stall_id=1 one cycle, bubble enters (ex_valid=0), bubble_count=1. Next cycle the add captures, and data1 equals memwb_result once the load reaches MEM/WB.
- alu_src with hazard on rt: id_uses_rt=0, rt=5 matches load rd -> no stall. id_uses_rt=1 -> stall. With alu_src=1, data2=id_imm while store_data is forwarded.
- Flush and hold: hold_in=1 for 3 cycles while memwb forwards 0x77 to rs on cycle 1 only -> data1 stays 0x77 after release. flush+hold_in together -> bubble loaded, stall_id=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding for the MIPS ALU.
// Captures decoded fields each clock and forwards from EX/MEM and MEM/WB.
// It inserts one bubble per load-use pair and stalls decode for that cycle.
// flush and a downstream hold are also handled here.
module ex_operand_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [4:0]      id_shamt,
  input  logic [CW-1:0]   id_alu_ctrl,
  input  logic            id_alu_src,
  input  logic            id_uses_rt,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            exmem_reg_write,
  input  logic [RW-1:0]   exmem_rd,
  input  logic [DW-1:0]   exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_rd,
  input  logic [DW-1:0]   memwb_result,
  input  logic            flush,
  input  logic            hold_in,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [DW-1:0]   data1,
  output logic [DW-1:0]   data2,
  output logic [CW-1:0]   alu_ctrl,
  output logic [4:0]      shamt,
  output logic [DW-1:0]   store_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic [CNTW-1:0] bubble_count
);

  logic            vld_p1;
  logic [RW-1:0]   rs_p1, rt_p1, rd_p1;
  logic [DW-1:0]   rs_data_p1, rt_data_p1, imm_p1;
  logic [4:0]      shamt_p1;
  logic [CW-1:0]   alu_ctrl_p1;
  logic            alu_src_p1, mem_read_p1, mem_write_p1, reg_write_p1;
  logic [CNTW-1:0] bubble_cnt_p1;

  logic            hazard;
  logic            load_bubble;
  logic [DW-1:0]   fwd_rs, fwd_rt;

  // Register 0 is hard-wired to zero; EX/MEM is younger and wins over MEM/WB.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] addr,
    input logic [DW-1:0] rf_val,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_val,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_val
  );
    if (addr == '0)                   return '0;
    else if (em_we && em_rd == addr)  return em_val;
    else if (mw_we && mw_rd == addr)  return mw_val;
    else                              return rf_val;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  // Load in EX whose destination a valid decode instruction reads next.
  always_comb begin
    hazard = vld_p1 && mem_read_p1 && reg_write_p1 && (rd_p1 != '0) &&
             ((rd_p1 == id_rs) || (id_uses_rt && (rd_p1 == id_rt))) && id_valid;
    stall_id    = hazard && !flush && !hold_in;
    load_bubble = flush || (!hold_in && (hazard || !id_valid));
  end

  // Operand forwarding on the registered source addresses.
  always_comb begin
    fwd_rs = fwd_sel(rs_p1, rs_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
    fwd_rt = fwd_sel(rt_p1, rt_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
  end

  // ---- ID/EX register boundary (p1) ----
  // A held stage re-captures forwarded operands so a retiring source is not lost.
  always_ff @(posedge clk) begin
    if (reset || (load_bubble && !(hold_in && !flush))) begin
      vld_p1       <= 1'b0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rd_p1        <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      imm_p1       <= '0;
      shamt_p1     <= '0;
      alu_ctrl_p1  <= '0;
      alu_src_p1   <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
    end else if (hold_in) begin
      rs_data_p1   <= fwd_rs;
      rt_data_p1   <= fwd_rt;
    end else begin
      vld_p1       <= 1'b1;
      rs_p1        <= id_rs;
      rt_p1        <= id_rt;
      rd_p1        <= id_rd;
      rs_data_p1   <= id_rs_data;
      rt_data_p1   <= id_rt_data;
      imm_p1       <= id_imm;
      shamt_p1     <= id_shamt;
      alu_ctrl_p1  <= id_alu_ctrl;
      alu_src_p1   <= id_alu_src;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
      reg_write_p1 <= id_reg_write;
    end
  end

  // Count bubbles inserted for load-use hazards.
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt_p1 <= '0;
    else if (stall_id)
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
  end

  // Drive the ALU-facing outputs from the registered stage.
  always_comb begin
    ex_valid     = vld_p1;
    data1        = fwd_rs;
    store_data   = fwd_rt;
    data2        = alu_src_p1 ? imm_p1 : fwd_rt;
    alu_ctrl     = alu_ctrl_p1;
    shamt        = shamt_p1;
    ex_rd        = rd_p1;
    ex_mem_read  = mem_read_p1;
    ex_mem_write = mem_write_p1;
    ex_reg_write = reg_write_p1;
    bubble_count = bubble_cnt_p1;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural model of the stage.
module tb_ex_operand_stage;
  localparam int DW = 32, RW = 5, CW = 4, CNTW = 4;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_alu_src, id_uses_rt, id_mem_read, id_mem_write, id_reg_write;
  logic [RW-1:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic [4:0] id_shamt;
  logic [CW-1:0] id_alu_ctrl;
  logic exmem_reg_write, memwb_reg_write, flush, hold_in;
  logic stall_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [DW-1:0] data1, data2, store_data;
  logic [CW-1:0] alu_ctrl;
  logic [4:0] shamt;
  logic [RW-1:0] ex_rd;
  logic [CNTW-1:0] bubble_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  ex_operand_stage #(.DW(DW), .RW(RW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .flush(flush), .hold_in(hold_in), .stall_id(stall_id),
    .ex_valid(ex_valid), .data1(data1), .data2(data2), .alu_ctrl(alu_ctrl), .shamt(shamt),
    .store_data(store_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .bubble_count(bubble_count)
  );

  // Behavioural model: contents of the ID/EX stage as a record.
  typedef struct packed {
    logic v;
    logic [RW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd, rtd, imm;
    logic [4:0] sh;
    logic [CW-1:0] ctl;
    logic src, mr, mw, rw;
  } stage_t;

  stage_t m = '0;
  int     m_cnt = 0;

  function automatic logic [DW-1:0] model_fwd(input logic [RW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return 0;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return rf;
  endfunction

  function automatic bit model_hazard();
    return m.v && m.mr && m.rw && m.rd != 0 && id_valid &&
           (m.rd == id_rs || (id_uses_rt && m.rd == id_rt));
  endfunction

  // Model update on each edge, following the reset > flush > hold > hazard > load order.
  always @(posedge clk) begin
    stage_t n;
    n = m;
    if (reset) begin
      n = '0; m_cnt <= 0;
    end else if (flush) begin
      n = '0;
    end else if (hold_in) begin
      n.rsd = model_fwd(m.rs, m.rsd);
      n.rtd = model_fwd(m.rt, m.rtd);
    end else if (model_hazard()) begin
      n = '0; m_cnt <= (m_cnt >= (1 << CNTW) - 1) ? m_cnt : m_cnt + 1;
    end else if (!id_valid) begin
      n = '0;
    end else begin
      n = '{1'b1, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_shamt,
            id_alu_ctrl, id_alu_src, id_mem_read, id_mem_write, id_reg_write};
    end
    m <= n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW-1:0] e1, e2;
      e1 = model_fwd(m.rs, m.rsd);
      e2 = model_fwd(m.rt, m.rtd);
      chk("m_stall_id", stall_id, model_hazard() && !flush && !hold_in);
      chk("m_ex_valid", ex_valid, m.v);
      chk("m_data1", data1, e1);
      chk("m_data2", data2, m.src ? m.imm : e2);
      chk("m_store_data", store_data, e2);
      chk("m_alu_ctrl", alu_ctrl, m.ctl);
      chk("m_shamt", shamt, m.sh);
      chk("m_ex_rd", ex_rd, m.rd);
      chk("m_mem_read", ex_mem_read, m.mr);
      chk("m_mem_write", ex_mem_write, m.mw);
      chk("m_reg_write", ex_reg_write, m.rw);
      chk("m_bubble_count", bubble_count, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alu_ctrl = 0; id_alu_src = 0; id_uses_rt = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
  endtask

  task automatic idle_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load_word(input logic [RW-1:0] rd);
    idle_id();
    id_valid = 1; id_rs = 1; id_rd = rd; id_mem_read = 1; id_reg_write = 1; id_alu_ctrl = 2;
  endtask

  initial begin
    reset = 1; flush = 0; hold_in = 0;
    idle_id(); idle_fwd();
    cyc();
    chk_en = 1;
    cyc();
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_bubble_count", bubble_count, 0);
    chk("reset_stall_id", stall_id, 0);
    reset = 0;

    // EX/MEM beats MEM/WB, then reset mid-stream.
    id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 6; id_rs_data = 32'h33;
    id_alu_ctrl = 2; id_reg_write = 1;
    cyc();
    idle_id();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
    #1 chk("fwd_exmem_prio", data1, 32'h11);
    chk("add_valid", ex_valid, 1);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", data1, 32'h22);
    reset = 1;
    cyc();
    reset = 0;
    #1 chk("midreset_valid", ex_valid, 0);
    chk("midreset_reg_write", ex_reg_write, 0);
    chk("midreset_alu_ctrl", alu_ctrl, 0);
    chk("midreset_bubbles", bubble_count, 0);

    // Register 0 is never forwarded.
    idle_fwd();
    id_valid = 1; id_rs = 0; id_rs_data = 32'h44; id_reg_write = 1;
    cyc();
    idle_id();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFF;
    #1 chk("reg0_data1", data1, 0);

    // Load-use on rs: one bubble, then forward from MEM/WB.
    idle_fwd();
    load_word(5);
    cyc();
    idle_id();
    id_valid = 1; id_rs = 5; id_rt = 2; id_rd = 8; id_reg_write = 1; id_alu_ctrl = 2; id_uses_rt = 1;
    #1 chk("lu_stall", stall_id, 1);
    cyc();
    #1 chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_count", bubble_count, 1);
    chk("lu_stall_clear", stall_id, 0);
    cyc();
    idle_id();
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hABC;
    #1 chk("lu_data1", data1, 32'hABC);
    chk("lu_add_valid", ex_valid, 1);

    // Hazard on rt only matters when rt is read; immediate is never forwarded.
    idle_fwd();
    load_word(5);
    cyc();
    idle_id();
    id_valid = 1; id_rs = 1; id_rt = 5; id_uses_rt = 0; id_alu_src = 1;
    id_imm = 32'h1234; id_rt_data = 32'h99; id_mem_write = 1;
    #1 chk("rt_nouse_stall", stall_id, 0);
    id_uses_rt = 1;
    #1 chk("rt_use_stall", stall_id, 1);
    cyc();
    cyc();
    idle_id();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h55;
    #1 chk("src_data2_imm", data2, 32'h1234);
    chk("src_store_fwd", store_data, 32'h55);
    chk("src_bubbles", bubble_count, 2);

    // Hold captures a forward that retires during the hold; flush beats hold.
    idle_fwd();
    load_word(9);
    id_rs = 7; id_rs_data = 32'h10;
    cyc();
    idle_id();
    id_valid = 1; id_rs = 9;
    hold_in = 1;
    memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h77;
    #1 chk("hold_stall", stall_id, 0);
    cyc();
    memwb_reg_write = 0;
    cyc();
    cyc();
    hold_in = 0;
    #1 chk("hold_data1", data1, 32'h77);
    chk("hold_hazard_stall", stall_id, 1);
    flush = 1; hold_in = 1;
    #1 chk("flush_hold_stall", stall_id, 0);
    cyc();
    flush = 0; hold_in = 0; idle_id();
    #1 chk("flush_valid", ex_valid, 0);
    chk("flush_bubbles", bubble_count, 2);

    // Repeated load-use pairs drive the counter into saturation.
    for (int i = 0; i < 20; i++) begin
      load_word(5);
      cyc();
      idle_id();
      id_valid = 1; id_rs = 5; id_reg_write = 1;
      cyc();
    end
    idle_id();
    #1 chk("sat_bubbles", bubble_count, 15);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      hold_in = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs = RW'($urandom_range(0, 7));
      id_rt = RW'($urandom_range(0, 7));
      id_rd = RW'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alu_ctrl = CW'($urandom);
      id_alu_src = 1'($urandom); id_uses_rt = 1'($urandom);
      id_mem_read = ($urandom_range(0, 9) < 3); id_mem_write = 1'($urandom);
      id_reg_write = ($urandom_range(0, 9) < 7);
      exmem_reg_write = 1'($urandom); exmem_rd = RW'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = RW'($urandom_range(0, 7));
      memwb_result = $urandom;
      cyc();
    end
    reset = 0; flush = 0; hold_in = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
